// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared defaults and the prefetch entry record for the fetch unit.
//            c_DEPTH_DEFAULT     - prefetch FIFO entries (power of two, >= 2)
//            c_AW_DEFAULT        - instruction word-address width
//            c_HALT_WORD_DEFAULT - encoding of the halt instruction
//            fetch_entry_t       - {pc, instr} record held in the FIFO
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          c_DEPTH_DEFAULT     = 4;
    localparam int          c_AW_DEFAULT        = 10;
    localparam logic [31:0] c_HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [c_AW_DEFAULT-1:0] pc;
        logic [31:0]             instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Prefetch FIFO holding {pc, instr} entries for the fetch unit.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_push/i_push_data - write one entry (ignored when full)
//            i_pop           - drop the head entry (ignored when empty)
//            i_flush         - discard all entries; overrides push and pop
//            o_full/o_empty/o_count - occupancy
//            o_head          - head entry (meaningful only when !o_empty)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CW-1:0] r_count_q,  w_count_d;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count_q == c_CW'(DEPTH));
    assign o_empty   = (r_count_q == '0);
    assign o_count   = r_count_q;
    assign o_head    = r_mem[r_rd_ptr_q];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_do_push) begin
                w_wr_ptr_d = r_wr_ptr_q + c_PW'(1);
            end
            if (w_do_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_d = r_count_q + c_CW'(1);
                2'b01:   w_count_d = r_count_q - c_CW'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr_q] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction prefetcher. Issues one-word reads ahead of the
//            datapath into a credit-controlled FIFO, handles redirects
//            (flush + squash) and stops fetching after a halt word.
// Ports    : clk, rst_n                  - clock, asynchronous active-low reset
//            imem_req/imem_addr          - instruction-memory read request
//            imem_rdata                  - read data, one cycle after request
//            redirect_valid/redirect_pc  - branch/jump redirect
//            out_valid/out_ready/out_instr/out_pc - instruction stream to datapath
//            halted                      - halt word fetched, fetching stopped
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = c_DEPTH_DEFAULT,
    parameter int          AW        = c_AW_DEFAULT,
    parameter logic [31:0] HALT_WORD = c_HALT_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_pc,
    output logic          halted
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_EW = AW + 32;

    logic [AW-1:0]   r_fetch_pc_q,    w_fetch_pc_d;
    logic            r_inflight_q,    w_inflight_d;
    logic [AW-1:0]   r_inflight_pc_q, w_inflight_pc_d;
    logic            r_halted_q,      w_halted_d;

    logic            w_full;
    logic            w_empty;
    logic [c_CW-1:0] w_count;
    logic [c_CW-1:0] w_used;
    logic [c_EW-1:0] w_head;
    logic            w_req;
    logic            w_capture;
    logic            w_push;
    logic            w_pop;

    // Credit: buffered entries plus the outstanding read may never exceed
    // DEPTH, so every response that comes back has a slot waiting for it.
    assign w_used = w_count + {{c_PW{1'b0}}, r_inflight_q};
    // rst_n gating keeps the strobe low while reset is held.
    assign w_req  = rst_n & ~r_halted_q & ~redirect_valid & (w_used < c_CW'(DEPTH));

    // A response is kept only if no redirect squashes it and no halt
    // has already been seen.
    assign w_capture = r_inflight_q & ~r_halted_q & ~redirect_valid;
    assign w_push    = w_capture & ~w_full;
    assign w_pop     = ~w_empty & out_ready;

    always_comb begin
        w_fetch_pc_d    = r_fetch_pc_q;
        w_inflight_d    = r_inflight_q;
        w_inflight_pc_d = r_inflight_pc_q;
        w_halted_d      = r_halted_q;
        if (redirect_valid) begin
            w_fetch_pc_d = redirect_pc;
            w_inflight_d = 1'b0;
            w_halted_d   = 1'b0;
        end else begin
            w_inflight_d = w_req;
            if (w_req) begin
                w_inflight_pc_d = r_fetch_pc_q;
                w_fetch_pc_d    = r_fetch_pc_q + AW'(1);
            end
            if (w_capture && (imem_rdata == HALT_WORD)) begin
                w_halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc_q    <= '0;
            r_inflight_q    <= 1'b0;
            r_inflight_pc_q <= '0;
            r_halted_q      <= 1'b0;
        end else begin
            r_fetch_pc_q    <= w_fetch_pc_d;
            r_inflight_q    <= w_inflight_d;
            r_inflight_pc_q <= w_inflight_pc_d;
            r_halted_q      <= w_halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (c_EW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({r_inflight_pc_q, imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc_q;
    assign halted    = r_halted_q;
    assign out_valid = ~w_empty;
    // Zero the data outputs when empty so unwritten storage never shows.
    assign out_pc    = w_empty ? '0 : w_head[c_EW-1:32];
    assign out_instr = w_empty ? '0 : w_head[31:0];

endmodule
`default_nettype wire
